halfword_compressor: RTL and testbench

- Inverse of the 16→32 sign-extension path: accepts 32-bit signed words and emits them as 16-bit beats on a narrow bus.
- A word that is exactly the sign extension of its low half is sent as one beat, flagged compressed. Any other word is sent as two beats: low half first, then high half.
- Valid/ready handshake on both sides, single-word holding buffer, running statistics counters.
- Sits between the 32-bit datapath and a 16-bit immediate/constant store or narrow link.

---
 rtl/halfword_compressor.sv | 119 +++++++++++
 tb/tb_halfword_compressor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/halfword_compressor.sv
// Narrows a stream of 32-bit signed words onto a 16-bit beat bus, sending a word
// as one compressed beat when it is the sign extension of its low half.
module halfword_compressor #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             out_compressed,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] compressed_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              flag_q, flag_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  comp_cnt_q, comp_cnt_d;
  logic              in_compressible;

  // Bits [31:15] all equal means the upper half carries only sign.
  assign in_compressible = (&in_data[WORD_W-1:HALF_W-1]) | ~(|in_data[WORD_W-1:HALF_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      word_q     <= '0;
      flag_q     <= 1'b0;
      word_cnt_q <= '0;
      comp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      flag_q     <= flag_d;
      word_cnt_q <= word_cnt_d;
      comp_cnt_q <= comp_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    flag_d         = flag_q;
    word_cnt_d     = word_cnt_q;
    comp_cnt_d     = comp_cnt_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_first      = 1'b0;
    out_last       = 1'b0;
    out_compressed = 1'b0;

    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
      end
      SEND_LO: begin
        out_valid      = 1'b1;
        out_data       = word_q[HALF_W-1:0];
        out_first      = 1'b1;
        out_last       = flag_q;
        out_compressed = flag_q;
        in_ready       = out_ready & flag_q;
        if (out_ready) begin
          state_d = flag_q ? EMPTY : SEND_HI;
        end
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_data  = word_q[WORD_W-1:HALF_W];
        out_last  = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // A free slot (empty, or last beat leaving) takes the next word with no bubble.
    if (in_valid && in_ready) begin
      state_d = SEND_LO;
      word_d  = in_data;
      flag_d  = in_compressible;
    end

    if (out_valid && out_ready && out_last) begin
      if (word_cnt_q != CNT_MAX) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
      if (out_compressed && (comp_cnt_q != CNT_MAX)) begin
        comp_cnt_d = comp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign word_count       = word_cnt_q;
  assign compressed_count = comp_cnt_q;

endmodule

// File: tb/tb_halfword_compressor.sv
// Directed and randomized bench for halfword_compressor, scored against a beat-queue
// model; a second instance with 2-bit counters covers saturation.
module tb_halfword_compressor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_first;
  logic        out_last;
  logic        out_compressed;
  logic [15:0] word_count;
  logic [15:0] compressed_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic        s_out_first;
  logic        s_out_last;
  logic        s_out_compressed;
  logic [1:0]  s_word_count;
  logic [1:0]  s_compressed_count;

  halfword_compressor #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .out_compressed(out_compressed),
    .word_count(word_count), .compressed_count(compressed_count)
  );

  halfword_compressor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_first(s_out_first), .out_last(s_out_last), .out_compressed(s_out_compressed),
    .word_count(s_word_count), .compressed_count(s_compressed_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
    logic        comp;
  } beat_t;

  beat_t       q[$];
  int unsigned cnt;
  int unsigned ccnt;
  int          errors = 0;
  int          checks = 0;
  logic        last_ifire;

  function automatic bit compressible(input logic [31:0] w);
    longint v;
    v = longint'($signed(w));
    return (v >= -32768) && (v <= 32767);
  endfunction

  function automatic int unsigned sat3(input int unsigned c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic push_word(input logic [31:0] w);
    if (compressible(w)) begin
      q.push_back('{data: w[15:0], first: 1'b1, last: 1'b1, comp: 1'b1});
    end else begin
      q.push_back('{data: w[15:0], first: 1'b1, last: 1'b0, comp: 1'b0});
      q.push_back('{data: w[31:16], first: 1'b0, last: 1'b1, comp: 1'b0});
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model by what transferred.
  task automatic cyc(input logic iv, input logic [31:0] id, input logic ordy);
    logic  exp_ir;
    logic  ofire;
    logic  ifire;
    beat_t b;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    exp_ir = (q.size() == 0) || (ordy && q[0].last);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("sat_out_valid", 32'(s_out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].data));
      chk("out_first", 32'(out_first), 32'(q[0].first));
      chk("out_last", 32'(out_last), 32'(q[0].last));
      chk("out_compressed", 32'(out_compressed), 32'(q[0].comp));
    end
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("word_count", 32'(word_count), cnt);
    chk("compressed_count", 32'(compressed_count), ccnt);
    chk("sat_word_count", 32'(s_word_count), sat3(cnt));
    chk("sat_compressed_count", 32'(s_compressed_count), sat3(ccnt));
    ofire = (q.size() != 0) && ordy;
    ifire = iv && exp_ir;
    if (ofire) begin
      b = q.pop_front();
      if (b.last) begin
        cnt++;
        if (b.comp) ccnt++;
      end
    end
    if (ifire) push_word(id);
    last_ifire = ifire;
    @(posedge clk);
    #1;
  endtask

  // Reset takes effect immediately; checked before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_first", 32'(out_first), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_compressed", 32'(out_compressed), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_compressed_count", 32'(compressed_count), 32'd0);
    chk("rst_sat_word_count", 32'(s_word_count), 32'd0);
    q.delete();
    cnt  = 0;
    ccnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      if (q.size() != 0) cyc(1'b0, 32'd0, 1'b1);
    end
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] bnd[4];
    logic [31:0] w;
    logic [31:0] r;
    logic        v;
    bnd = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_7FFF};
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    last_ifire = 1'b0;
    cnt        = 0;
    ccnt       = 0;
    do_reset();

    // Single compressed word
    cyc(1'b1, 32'h0000_000A, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("tp1_word_count", 32'(word_count), 32'd1);

    // Back-to-back compressed words
    cyc(1'b1, 32'hFFFF_FFE8, 1'b1);
    cyc(1'b1, 32'hFFFF_8000, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("tp2_compressed_count", 32'(compressed_count), 32'd3);

    // Uncompressed then compressed
    cyc(1'b1, 32'h0000_8000, 1'b1);
    drain();
    cyc(1'b1, 32'h0000_08BD, 1'b1);
    drain();
    cyc(1'b0, 32'd0, 1'b1);

    // Output stall with a second word waiting
    cyc(1'b1, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hAAAA_0001, 1'b0);
    cyc(1'b1, 32'hAAAA_0001, 1'b1);
    cyc(1'b1, 32'hAAAA_0001, 1'b1);
    chk("tp4_second_captured", 32'(last_ifire), 32'd1);
    drain();

    // Reset in the middle of a two-beat word
    cyc(1'b1, 32'h0000_8000, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("pre_rst_hi_pending", 32'(out_data), 32'h0000);
    do_reset();
    cyc(1'b1, 32'hFFFF_FB2E, 1'b1);
    drain();
    cyc(1'b0, 32'd0, 1'b1);

    // Compressibility boundaries
    for (int i = 0; i < 4; i++) cyc(1'b1, bnd[i], 1'b1);
    drain();

    // Saturation of the 2-bit counters
    do_reset();
    cyc(1'b1, 32'h0000_0001, 1'b1);
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1);
    cyc(1'b1, 32'h0000_0100, 1'b1);
    cyc(1'b1, 32'hFFFF_8000, 1'b1);
    cyc(1'b1, 32'h0000_7FFF, 1'b1);
    drain();
    cyc(1'b0, 32'd0, 1'b1);
    chk("sat_word_count_final", 32'(s_word_count), 32'd3);
    chk("sat_comp_count_final", 32'(s_compressed_count), 32'd3);
    chk("word_count_final", 32'(word_count), 32'd5);

    // Randomized traffic, upstream holds an unaccepted word
    v = 1'b0;
    w = '0;
    for (int n = 0; n < 400; n++) begin
      if (!(v && !last_ifire)) begin
        v = ($urandom_range(0, 9) < 7);
        r = $urandom;
        case ($urandom_range(0, 3))
          0:       w = {{17{r[15]}}, r[14:0]};
          1:       w = bnd[r[1:0]];
          default: w = $urandom;
        endcase
      end
      cyc(v, w, ($urandom_range(0, 9) < 7));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
